// File: rtl/pll_phase_ctrl_if.sv
// Request handshake and PLL phase-pin bundle for pll_phase_ctrl.
// The requester holds the master side; the controller holds the slave side.
interface pll_phase_ctrl_if #(
   parameter int STEP_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_sel;
   logic              req_dir;
   logic [STEP_W-1:0] req_steps;
   logic [1:0]        phasesel;
   logic              phasedir;
   logic              phasestep;
   logic              phaseloadreg;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output req_valid, req_sel, req_dir, req_steps,
      input  req_ready, phasesel, phasedir, phasestep, phaseloadreg, busy, done, err
   );

   modport slave (
      input  req_valid, req_sel, req_dir, req_steps,
      output req_ready, phasesel, phasedir, phasestep, phaseloadreg, busy, done, err
   );
endinterface

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL lock supervisor and dynamic phase-step sequencer.
// Runs in the reference-clock domain; pll_locked is synchronised before any use.
module pll_phase_ctrl #(
   parameter int STEP_W             = 8,
   parameter int SETUP_CYCLES       = 2,
   parameter int PULSE_CYCLES       = 4,
   parameter int HOLD_CYCLES        = 2,
   parameter int GAP_CYCLES         = 8,
   parameter int LOCK_STABLE_CYCLES = 1024
) (
   input  logic            i_clk,
   input  logic            i_resetn,
   input  logic            i_pll_locked,
   output logic            o_sys_resetn,
   pll_phase_ctrl_if.slave bus
);

   localparam int T_AB  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
   localparam int T_CD  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int T_MAX = (T_AB > T_CD) ? T_AB : T_CD;
   localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam int LK_W  = $clog2(LOCK_STABLE_CYCLES + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [LK_W-1:0]  LK_FULL    = LK_W'(LOCK_STABLE_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_GAP, S_DONE
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_tcnt, w_tcnt_nxt;
   logic [STEP_W-1:0] r_remain, w_remain_nxt;
   logic              r_lk_p0, r_lk_p1;
   logic [LK_W-1:0]   r_stable;
   logic              r_sys_resetn;
   logic [1:0]        r_phasesel;
   logic              r_phasedir;
   logic              r_phasestep;
   logic              r_err;
   logic              w_lk;
   logic              w_req_ready;
   logic              w_accept;
   logic              w_abort;

   assign w_lk        = r_lk_p1;
   assign w_req_ready = (r_state == S_IDLE) & r_sys_resetn;
   assign w_accept    = bus.req_valid & w_req_ready;

   // Lock synchroniser and stability window; any low lk cycle restarts the window
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_lk_p0      <= 1'b0;
         r_lk_p1      <= 1'b0;
         r_stable     <= '0;
         r_sys_resetn <= 1'b0;
      end else begin
         r_lk_p0 <= i_pll_locked;
         r_lk_p1 <= r_lk_p0;
         if (!w_lk)
            r_stable <= '0;
         else if (r_stable != LK_FULL)
            r_stable <= r_stable + LK_W'(1);
         r_sys_resetn <= w_lk & (r_stable == LK_FULL);
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_tcnt_nxt   = r_tcnt;
      w_remain_nxt = r_remain;
      w_abort      = 1'b0;
      if (!w_lk && (r_state != S_IDLE) && (r_state != S_DONE)) begin
         w_abort      = 1'b1;
         w_state_nxt  = S_IDLE;
         w_tcnt_nxt   = '0;
         w_remain_nxt = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  w_remain_nxt = bus.req_steps;
                  w_tcnt_nxt   = '0;
                  w_state_nxt  = (bus.req_steps == '0) ? S_DONE : S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_tcnt == SETUP_LAST) begin
                  w_tcnt_nxt  = '0;
                  w_state_nxt = S_PULSE;
               end else begin
                  w_tcnt_nxt = r_tcnt + CNT_W'(1);
               end
            end
            S_PULSE: begin
               if (r_tcnt == PULSE_LAST) begin
                  w_tcnt_nxt  = '0;
                  w_state_nxt = S_HOLD;
                  if (r_remain != '0)
                     w_remain_nxt = r_remain - STEP_W'(1);
               end else begin
                  w_tcnt_nxt = r_tcnt + CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (r_tcnt == HOLD_LAST) begin
                  w_tcnt_nxt  = '0;
                  w_state_nxt = (r_remain == '0) ? S_DONE : S_GAP;
               end else begin
                  w_tcnt_nxt = r_tcnt + CNT_W'(1);
               end
            end
            S_GAP: begin
               if (r_tcnt == GAP_LAST) begin
                  w_tcnt_nxt  = '0;
                  w_state_nxt = S_PULSE;
               end else begin
                  w_tcnt_nxt = r_tcnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               w_tcnt_nxt  = '0;
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_tcnt_nxt  = '0;
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // phasestep follows the next state so the pin itself is a flop output
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state     <= S_IDLE;
         r_tcnt      <= '0;
         r_remain    <= '0;
         r_phasesel  <= 2'd0;
         r_phasedir  <= 1'b1;
         r_phasestep <= 1'b1;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tcnt      <= w_tcnt_nxt;
         r_remain    <= w_remain_nxt;
         r_phasestep <= (w_state_nxt != S_PULSE);
         r_err       <= w_abort;
         if (w_accept) begin
            r_phasesel <= bus.req_sel;
            r_phasedir <= bus.req_dir;
         end
      end
   end

   assign o_sys_resetn     = r_sys_resetn;
   assign bus.req_ready    = w_req_ready;
   assign bus.phasesel     = r_phasesel;
   assign bus.phasedir     = r_phasedir;
   assign bus.phasestep    = r_phasestep;
   assign bus.phaseloadreg = 1'b1;
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.done         = (r_state == S_DONE);
   assign bus.err          = r_err;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl: lock-up, glitch, single/burst/zero/back-to-back,
// max-step and abort sequences with hand-computed cycle positions relative to accept.
module tb_pll_phase_ctrl;

   logic clk = 1'b0;
   logic resetn;
   logic pll_locked;
   logic sys_resetn;

   int n_pass  = 0;
   int n_total = 0;

   logic [63:0] m_low, m_busy, m_done, m_err, m_rdy, m_srst;
   logic [1:0]  sel_tr [64];
   logic        dir_tr [64];

   pll_phase_ctrl_if #(.STEP_W(8)) bus ();

   pll_phase_ctrl #(
      .STEP_W(8), .SETUP_CYCLES(2), .PULSE_CYCLES(4), .HOLD_CYCLES(2),
      .GAP_CYCLES(8), .LOCK_STABLE_CYCLES(1024)
   ) dut (
      .i_clk        (clk),
      .i_resetn     (resetn),
      .i_pll_locked (pll_locked),
      .o_sys_resetn (sys_resetn),
      .bus          (bus)
   );

   always #20 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.req_ready && n < 3000) begin
         tick();
         n++;
      end
      if (!bus.req_ready) chk("ready_timeout", {63'd0, bus.req_ready}, 64'd1);
   endtask

   task automatic start(input logic [1:0] s, input logic d, input logic [7:0] n);
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_sel   = s;
      bus.req_dir   = d;
      bus.req_steps = n;
   endtask

   // Bit j of each mask is the observation j cycles after the accept cycle
   task automatic capture(input int n, input int drop_valid_at, input int lock_off_at,
                          input int lock_on_at, input logic [1:0] nsel, input logic ndir,
                          input logic [7:0] nsteps);
      m_low = '0; m_busy = '0; m_done = '0; m_err = '0; m_rdy = '0; m_srst = '0;
      for (int j = 1; j <= n; j++) begin
         tick();
         m_low[j]  = ~bus.phasestep;
         m_busy[j] = bus.busy;
         m_done[j] = bus.done;
         m_err[j]  = bus.err;
         m_rdy[j]  = bus.req_ready;
         m_srst[j] = sys_resetn;
         sel_tr[j] = bus.phasesel;
         dir_tr[j] = bus.phasedir;
         if (j == 1) begin
            bus.req_sel   = nsel;
            bus.req_dir   = ndir;
            bus.req_steps = nsteps;
         end
         if (j == drop_valid_at) bus.req_valid = 1'b0;
         if (j == lock_off_at) pll_locked = 1'b0;
         if (j == lock_on_at) pll_locked = 1'b1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int   rise, rdy_before, rdy_at_rise, lows, pulses, done_at, errs, ok;
      logic prev, srst_chk, rdy_chk;

      resetn = 1'b0; pll_locked = 1'b0;
      bus.req_valid = 1'b0; bus.req_sel = 2'd0; bus.req_dir = 1'b0; bus.req_steps = 8'd0;
      repeat (3) tick();
      chk("rst_sys_resetn", {63'd0, sys_resetn}, 64'd0);
      chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
      chk("rst_phasesel", {62'd0, bus.phasesel}, 64'd0);
      chk("rst_phasedir", {63'd0, bus.phasedir}, 64'd1);
      chk("rst_phasestep", {63'd0, bus.phasestep}, 64'd1);
      chk("rst_phaseloadreg", {63'd0, bus.phaseloadreg}, 64'd1);
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_done", {63'd0, bus.done}, 64'd0);
      chk("rst_err", {63'd0, bus.err}, 64'd0);

      // Lock-up: locked from cycle 5, release at 5+2+1024+1
      resetn = 1'b1;
      rise = -1; rdy_before = 0; rdy_at_rise = 0;
      for (int k = 1; k <= 1500 && rise < 0; k++) begin
         tick();
         if (sys_resetn) begin
            rise = k;
            rdy_at_rise = int'(bus.req_ready);
         end else if (bus.req_ready) begin
            rdy_before++;
         end
         if (k == 5) pll_locked = 1'b1;
      end
      chk("lockup_rise_cycle", 64'(rise), 64'd1032);
      chk("lockup_ready_at_rise", 64'(rdy_at_rise), 64'd1);
      chk("lockup_ready_early", 64'(rdy_before), 64'd0);

      // Single step
      start(2'd1, 1'b1, 8'd1);
      capture(63, 1, -1, -1, 2'd1, 1'b1, 8'd1);
      chk("single_sel", {62'd0, sel_tr[1]}, 64'd1);
      chk("single_dir", {63'd0, dir_tr[1]}, 64'd1);
      chk("single_step_low", m_low, 64'h78);
      chk("single_busy", m_busy, 64'h3FE);
      chk("single_done", m_done, 64'h200);
      chk("single_ready", m_rdy, 64'hFFFF_FFFF_FFFF_FC00);
      chk("single_err", m_err, 64'd0);

      // Burst of three
      start(2'd2, 1'b0, 8'd3);
      capture(63, 1, -1, -1, 2'd2, 1'b0, 8'd3);
      ok = 0;
      for (int j = 1; j <= 37; j++) if (sel_tr[j] == 2'd2 && dir_tr[j] == 1'b0) ok++;
      chk("burst_sel_steady", 64'(ok), 64'd37);
      chk("burst_step_low", m_low, 64'h0000_0007_801E_0078);
      chk("burst_done", m_done, 64'h0000_0020_0000_0000);
      chk("burst_busy", m_busy, 64'h0000_003F_FFFF_FFFE);
      chk("burst_sel_held", {62'd0, sel_tr[63]}, 64'd2);

      // Zero steps
      start(2'd2, 1'b0, 8'd0);
      capture(63, 1, -1, -1, 2'd2, 1'b0, 8'd0);
      chk("zero_step_low", m_low, 64'd0);
      chk("zero_done", m_done, 64'd2);
      chk("zero_busy", m_busy, 64'd2);
      chk("zero_ready", m_rdy, 64'hFFFF_FFFF_FFFF_FFFC);

      // Back-to-back with req_valid held; second request accepted at T+10
      start(2'd1, 1'b1, 8'd1);
      capture(63, 11, -1, -1, 2'd3, 1'b0, 8'd2);
      chk("b2b_sel_while_busy", {62'd0, sel_tr[10]}, 64'd1);
      chk("b2b_sel_second", {62'd0, sel_tr[11]}, 64'd3);
      chk("b2b_step_low", m_low, 64'h0000_0000_7801_E078);
      chk("b2b_done", m_done, 64'h0000_0002_0000_0200);

      // Max steps, no wrap
      start(2'd1, 1'b0, 8'hFF);
      lows = 0; pulses = 0; done_at = -1; prev = 1'b1;
      for (int j = 1; j <= 5000 && done_at < 0; j++) begin
         tick();
         if (j == 1) bus.req_valid = 1'b0;
         if (!bus.phasestep) lows++;
         if (prev && !bus.phasestep) pulses++;
         prev = bus.phasestep;
         if (bus.done) done_at = j;
      end
      chk("max_done_cycle", 64'(done_at), 64'd3565);
      chk("max_pulses", 64'(pulses), 64'd255);
      chk("max_low_cycles", 64'(lows), 64'd1020);

      // Abort: lock dropped in cycle T+18 (second pulse), restored at T+25
      start(2'd3, 1'b1, 8'd5);
      capture(63, 1, 18, 25, 2'd3, 1'b1, 8'd5);
      chk("abort_step_low", m_low, 64'h1E_0078);
      chk("abort_err", m_err, 64'h20_0000);
      chk("abort_done", m_done, 64'd0);
      chk("abort_busy", m_busy, 64'h1F_FFFE);
      chk("abort_sys_resetn", m_srst, 64'h1F_FFFE);
      chk("abort_ready", m_rdy, 64'd0);
      rise = -1; rdy_before = 0;
      for (int j = 64; j <= 2000 && rise < 0; j++) begin
         tick();
         if (sys_resetn) rise = j;
         else if (bus.req_ready) rdy_before++;
      end
      chk("abort_relock_cycle", 64'(rise), 64'd1052);
      chk("abort_ready_held", 64'(rdy_before), 64'd0);
      chk("abort_ready_back", {63'd0, bus.req_ready}, 64'd1);

      // Lock glitch after fresh reset, then a lock loss while idle
      resetn = 1'b0; pll_locked = 1'b0;
      repeat (2) tick();
      resetn = 1'b1;
      rise = -1; errs = 0; srst_chk = 1'b1; rdy_chk = 1'b1;
      for (int k = 1; k <= 1620; k++) begin
         tick();
         if (sys_resetn && rise < 0) rise = k;
         if (bus.err) errs++;
         if (k == 1610) begin
            srst_chk = sys_resetn;
            rdy_chk  = bus.req_ready;
         end
         pll_locked = ((k >= 5 && k <= 504) || (k >= 508 && k <= 1599) || k >= 1604);
      end
      chk("glitch_rise_cycle", 64'(rise), 64'd1535);
      chk("idle_lockloss_err", 64'(errs), 64'd0);
      chk("idle_lockloss_srst", {63'd0, srst_chk}, 64'd0);
      chk("idle_lockloss_ready", {63'd0, rdy_chk}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
